// File: rtl/multicycle_pkg.sv
// Shared types for the multicycle datapath and its controller.
//   state_e    : datapath sequencing states
//   sel_e      : decoded operand select
//   decode_sel : maps the controller's {s0,s1,s2} to sel_e; unknown or illegal codes
//                with s0 set decode to SelBad
package multicycle_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  typedef enum logic [2:0] {SelA, SelB, SelC, SelD, SelBad} sel_e;

  function automatic sel_e decode_sel(input logic s0, input logic s1, input logic s2);
    sel_e sel;
    sel = SelBad;
    case (s0)
      1'b0: sel = SelA;
      1'b1: begin
        case ({s1, s2})
          2'b00:   sel = SelB;
          2'b10:   sel = SelC;
          2'b01:   sel = SelD;
          default: sel = SelBad;
        endcase
      end
      default: sel = SelBad;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_operand_mux.sv
// Operand selector for the multicycle datapath.
//   op_a..op_d : captured operands
//   s0, s1, s2 : controller select lines
//   operand    : selected operand (0 on an illegal select)
//   is_load    : select is A, so the accumulator is loaded rather than stepped
//   sel_bad    : select is illegal
module multicycle_operand_mux
  import multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  input  logic [WIDTH-1:0] op_d,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] operand,
  output logic             is_load,
  output logic             sel_bad
);

  sel_e sel;

  always_comb begin
    sel     = decode_sel(s0, s1, s2);
    operand = '0;
    is_load = 1'b0;
    sel_bad = 1'b0;
    case (sel)
      SelA: begin
        operand = op_a;
        is_load = 1'b1;
      end
      SelB:    operand = op_b;
      SelC:    operand = op_c;
      SelD:    operand = op_d;
      default: sel_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Accumulating datapath driven by the multicycle controller.
// Captures signed operands a..d on start, steps an accumulator on each enabled controller
// cycle, and presents the final value with sticky overflow / illegal-select flags on a
// valid/ready port.
//   clock, reset          : clock, asynchronous active-low reset
//   start, a, b, c, d     : operand capture request and operands
//   e, s0, s1, s2         : step enable and operand select
//   addOrSub, done        : 1 = add / 0 = subtract, end of sequence
//   busy                  : sequence in progress (RUN or HOLD)
//   result, ovf, sel_err  : final accumulator and sticky flags
//   out_valid, out_ready  : output handshake
module multicycle_datapath
  import multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             e,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             addOrSub,
  input  logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             sel_err,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, op_c_q, op_d_q;
  logic [WIDTH-1:0] acc_q, result_q;
  logic             ovf_acc_q, err_acc_q;
  logic             ovf_q, sel_err_q, out_valid_q, busy_q;

  logic [WIDTH-1:0] mux_operand;
  logic             mux_load, mux_bad;

  logic [WIDTH-1:0] acc_next;
  logic             ovf_next, err_next;
  logic [WIDTH:0]   sum_ext;

  multicycle_operand_mux #(
    .WIDTH(WIDTH)
  ) u_operand_mux (
    .op_a    (op_a_q),
    .op_b    (op_b_q),
    .op_c    (op_c_q),
    .op_d    (op_d_q),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .operand (mux_operand),
    .is_load (mux_load),
    .sel_bad (mux_bad)
  );

  // One guard bit: the sum is exact in WIDTH+1 bits, so overflow is simply the guard bit
  // disagreeing with the result sign. This also covers subtracting the most-negative value.
  always_comb begin
    acc_next = acc_q;
    ovf_next = ovf_acc_q;
    err_next = err_acc_q;
    sum_ext  = '0;
    if (state_q == StRun && e) begin
      if (mux_load) begin
        acc_next = mux_operand;
      end else begin
        if (addOrSub) begin
          sum_ext = {acc_q[WIDTH-1], acc_q} + {mux_operand[WIDTH-1], mux_operand};
        end else begin
          sum_ext = {acc_q[WIDTH-1], acc_q} - {mux_operand[WIDTH-1], mux_operand};
        end
        acc_next = sum_ext[WIDTH-1:0];
        ovf_next = ovf_acc_q | (sum_ext[WIDTH] ^ sum_ext[WIDTH-1]);
        err_next = err_acc_q | mux_bad;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= '0;
      op_d_q      <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      err_acc_q   <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      sel_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            op_a_q    <= a;
            op_b_q    <= b;
            op_c_q    <= c;
            op_d_q    <= d;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            err_acc_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StRun;
          end
        end
        StRun: begin
          acc_q     <= acc_next;
          ovf_acc_q <= ovf_next;
          err_acc_q <= err_next;
          if (done) begin
            result_q    <= acc_next;
            ovf_q       <= ovf_next;
            sel_err_q   <= err_next;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign sel_err   = sel_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

  localparam int W    = 8;
  localparam int MaxV = 2 ** (W - 1) - 1;
  localparam int MinV = -(2 ** (W - 1));
  localparam int Span = 2 ** W;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b, c, d;
  logic         e, s0, s1, s2, addOrSub, done, out_ready;
  logic         busy, ovf, sel_err, out_valid;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  multicycle_datapath #(
    .WIDTH(W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .addOrSub  (addOrSub),
    .done      (done),
    .busy      (busy),
    .result    (result),
    .ovf       (ovf),
    .sel_err   (sel_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    int a, b, c, d;
    bit mode;
    bit bad_c;
    int res;
    bit ovf;
    bit err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Reference: mode 0 is A+B+C-D, mode 1 is A-B+C+D, computed on unbounded integers;
  // any intermediate outside the signed range sets the overflow flag, then wraps.
  function automatic void model(input int av, input int bv, input int cv, input int dv,
                                input bit mode, input bit [3:1] bad,
                                output int res, output bit o, output bit err);
    int v[4];
    int sgn[4];
    int acc, t, op;
    v = '{av, bv, cv, dv};
    if (mode) sgn = '{0, -1, 1, 1};
    else      sgn = '{0, 1, 1, -1};
    acc = av;
    o   = 1'b0;
    err = 1'b0;
    for (int i = 1; i < 4; i++) begin
      op = bad[i] ? 0 : v[i];
      t  = acc + sgn[i] * op;
      if (t > MaxV || t < MinV) o = 1'b1;
      acc = ((t - MinV) % Span + Span) % Span + MinV;
      if (bad[i]) err = 1'b1;
    end
    res = acc;
  endfunction

  function automatic bit step_add(input bit mode, input int k);
    return mode ? (k != 1) : (k != 3);
  endfunction

  task automatic drive_sel(input int k, input bit bad);
    if (bad) begin
      s0 = 1'b1; s1 = 1'b1; s2 = 1'b1;
    end else begin
      case (k)
        0: begin s0 = 1'b0; s1 = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1)); end
        1: begin s0 = 1'b1; s1 = 1'b0; s2 = 1'b0; end
        2: begin s0 = 1'b1; s1 = 1'b1; s2 = 1'b0; end
        default: begin s0 = 1'b1; s1 = 1'b0; s2 = 1'b1; end
      endcase
    end
  endtask

  task automatic scramble_inputs();
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
    d = W'($urandom);
  endtask

  // Full controller-style sequence: capture, steps A..D (done on the D step), then hold
  // for ready_delay cycles with start poked and operands changed, then accept.
  task automatic run_seq(input int av, input int bv, input int cv, input int dv,
                         input bit mode, input bit [3:1] bad, input bit gaps,
                         input int ready_delay, input int exp_res, input bit exp_ovf,
                         input bit exp_err, input string tag);
    @(negedge clock);
    start = 1'b1; a = av[W-1:0]; b = bv[W-1:0]; c = cv[W-1:0]; d = dv[W-1:0];
    e = 1'b0; done = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check({tag, ".busy_run"}, 32'(busy), 32'd1);
    scramble_inputs();
    for (int k = 0; k < 4; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        e = 1'b0;
        s0 = 1'($urandom_range(0, 1)); s1 = 1'($urandom_range(0, 1));
        s2 = 1'($urandom_range(0, 1)); addOrSub = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      e = 1'b1;
      drive_sel(k, (k > 0) ? bad[k] : 1'b0);
      addOrSub = (k == 0) ? 1'($urandom_range(0, 1)) : step_add(mode, k);
      done = (k == 3);
      if (k == 3) check({tag, ".no_early_valid"}, 32'(out_valid), 32'd0);
      @(negedge clock);
    end
    e = 1'b0; done = 1'b0;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, 32'($signed(result)), 32'(exp_res));
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, ".sel_err"}, 32'(sel_err), 32'(exp_err));
    for (int i = 0; i < ready_delay; i++) begin
      start = 1'b1;
      scramble_inputs();
      @(negedge clock);
      check({tag, ".held_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".held_result"}, 32'($signed(result)), 32'(exp_res));
    end
    out_ready = 1'b1;
    start = 1'b1;
    scramble_inputs();
    @(negedge clock);
    out_ready = 1'b0;
    start = 1'b0;
    check({tag, ".accepted_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".accepted_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int rres;
    bit rovf, rerr;
    int ra, rb, rc, rd;
    bit rmode;
    bit [3:1] rbad;

    reset = 1'b0; start = 1'b0; e = 1'b0; done = 1'b0; out_ready = 1'b0;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; addOrSub = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    @(negedge clock);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.ovf", 32'(ovf), 32'd0);
    check("reset.sel_err", 32'(sel_err), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;

    vecs[0] = '{10, 20, 30, 5, 1'b0, 1'b0, 55, 1'b0, 1'b0};
    vecs[1] = '{10, 20, 30, 5, 1'b1, 1'b0, 25, 1'b0, 1'b0};
    vecs[2] = '{100, 50, 0, 0, 1'b0, 1'b0, -106, 1'b1, 1'b0};
    vecs[3] = '{1, 1, 1, 1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[4] = '{0, 0, 0, -128, 1'b0, 1'b0, -128, 1'b1, 1'b0};
    vecs[5] = '{-128, 1, 0, 0, 1'b1, 1'b0, 127, 1'b1, 1'b0};
    vecs[6] = '{-1, -128, 0, 0, 1'b1, 1'b0, 127, 1'b0, 1'b0};
    vecs[7] = '{-100, -100, -100, 0, 1'b0, 1'b0, -44, 1'b1, 1'b0};
    vecs[8] = '{10, 20, 30, 5, 1'b0, 1'b1, 25, 1'b0, 1'b1};

    foreach (vecs[i]) begin
      run_seq(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].mode,
              vecs[i].bad_c ? 3'b010 : 3'b000, 1'b0, 0,
              vecs[i].res, vecs[i].ovf, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Consumer stalls five cycles while start is pulsed and operands change.
    run_seq(10, 20, 30, 5, 1'b0, 3'b000, 1'b0, 5, 55, 1'b0, 1'b0, "hold");

    // Reset two cycles into RUN: every output clears without waiting for a clock edge.
    @(negedge clock);
    start = 1'b1; a = 8'd50; b = 8'd60; c = 8'd7; d = 8'd9;
    @(negedge clock);
    start = 1'b0; e = 1'b1; drive_sel(0, 1'b0); addOrSub = 1'b1;
    @(negedge clock);
    drive_sel(1, 1'b0);
    @(negedge clock);
    check("midrun.busy_before", 32'(busy), 32'd1);
    e = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("midrun.busy", 32'(busy), 32'd0);
    check("midrun.result", 32'(result), 32'd0);
    check("midrun.ovf", 32'(ovf), 32'd0);
    check("midrun.sel_err", 32'(sel_err), 32'd0);
    check("midrun.out_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_seq(3, 1, 1, 1, 1'b0, 3'b000, 1'b0, 0, 4, 1'b0, 1'b0, "fresh");

    for (int n = 0; n < 40; n++) begin
      ra = int'($urandom_range(0, Span - 1)) + MinV;
      rb = int'($urandom_range(0, Span - 1)) + MinV;
      rc = int'($urandom_range(0, Span - 1)) + MinV;
      rd = int'($urandom_range(0, Span - 1)) + MinV;
      rmode = 1'($urandom_range(0, 1));
      for (int k = 1; k < 4; k++) rbad[k] = ($urandom_range(0, 7) == 0);
      model(ra, rb, rc, rd, rmode, rbad, rres, rovf, rerr);
      run_seq(ra, rb, rc, rd, rmode, rbad, 1'b1, int'($urandom_range(0, 2)),
              rres, rovf, rerr, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
